// File: rtl/inv4.sv
// Bitwise inverter with registered copy, popcount of the inverted word and saturating change counter.
// Latency: y and ones are combinational (0 cycles); y_q and chg_cnt update 1 cycle after an enabled edge.
// Backpressure: none; en gates every register update, and with en low all state holds.
module inv4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a,
  input  logic                       en,
  output logic [WIDTH-1:0]           y,
  output logic [WIDTH-1:0]           y_q,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  output logic [CNT_W-1:0]           chg_cnt
);

  localparam int OW = $clog2(WIDTH + 1);

  // Last enabled sample of a; resets to zero so the first enabled edge
  // after reset only counts a change when a is non-zero.
  logic [WIDTH-1:0] a_prev;

  // The live path stays independent of clock and reset.
  assign y = ~a;

  // Count the set bits of the inverted word.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OW'(y[i]);
    end
  end

  // Capture the inverted value and the raw sample on enabled edges; reset clears to the complement of a_prev's reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '1;
      a_prev <= '0;
    end else if (en) begin
      y_q    <= ~a;
      a_prev <= a;
    end
  end

  // Count enabled cycles where a differs from the last sample, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt <= '0;
    end else if (en && (a != a_prev) && (chg_cnt != {CNT_W{1'b1}})) begin
      chg_cnt <= chg_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inv4.sv
module tb_inv4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a;
  logic        en;
  logic [3:0]  y;
  logic [3:0]  y_q;
  logic [2:0]  ones;
  logic [15:0] chg_cnt;

  // Second build with a 2-bit counter for the saturation case.
  logic [3:0]  sa;
  logic        sen;
  logic [3:0]  sy;
  logic [3:0]  sy_q;
  logic [2:0]  sones;
  logic [1:0]  scnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv4 #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .en(en),
    .y(y), .y_q(y_q), .ones(ones), .chg_cnt(chg_cnt)
  );

  inv4 #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(sa), .en(sen),
    .y(sy), .y_q(sy_q), .ones(sones), .chg_cnt(scnt)
  );

  typedef struct {
    logic [3:0]  a;
    logic        en;
    logic [3:0]  y;
    logic [2:0]  ones;
    logic [3:0]  y_q;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  y_q;
    logic [15:0] cnt;
    logic [3:0]  sy_q;
    logic [1:0]  scnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=%0d expected=1", name, sb.size());
    end else begin
      e = sb.pop_front();
      check({name, "_y_q"},     {28'd0, y_q},     {28'd0, e.y_q});
      check({name, "_cnt"},     {16'd0, chg_cnt}, {16'd0, e.cnt});
      check({name, "_sat_y_q"}, {28'd0, sy_q},    {28'd0, e.sy_q});
      check({name, "_sat_cnt"}, {30'd0, scnt},    {30'd0, e.scnt});
    end
  endtask

  // Drive both instances at a falling edge, push expectation, compare after the next rising edge.
  task automatic step(input string name, input logic [3:0] ai, input logic ei,
                      input logic [3:0] sai, input logic sei, input exp_t e);
    @(negedge clk);
    a   = ai;
    en  = ei;
    sa  = sai;
    sen = sei;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare(name);
  endtask

  initial begin
    exp_t e;

    //            a     en    y     ones  y_q   cnt
    vecs[0]  = '{4'h3, 1'b1, 4'hC, 3'd2, 4'hC, 16'd1};
    vecs[1]  = '{4'h3, 1'b1, 4'hC, 3'd2, 4'hC, 16'd1};
    vecs[2]  = '{4'h3, 1'b1, 4'hC, 3'd2, 4'hC, 16'd1};
    vecs[3]  = '{4'h3, 1'b1, 4'hC, 3'd2, 4'hC, 16'd1};
    vecs[4]  = '{4'h1, 1'b0, 4'hE, 3'd3, 4'hC, 16'd1};
    vecs[5]  = '{4'h2, 1'b0, 4'hD, 3'd3, 4'hC, 16'd1};
    vecs[6]  = '{4'h1, 1'b0, 4'hE, 3'd3, 4'hC, 16'd1};
    vecs[7]  = '{4'h2, 1'b0, 4'hD, 3'd3, 4'hC, 16'd1};
    vecs[8]  = '{4'h2, 1'b1, 4'hD, 3'd3, 4'hD, 16'd2};
    vecs[9]  = '{4'h0, 1'b1, 4'hF, 3'd4, 4'hF, 16'd3};
    vecs[10] = '{4'h0, 1'b1, 4'hF, 3'd4, 4'hF, 16'd3};
    vecs[11] = '{4'h8, 1'b1, 4'h7, 3'd3, 4'h7, 16'd4};
    vecs[12] = '{4'h5, 1'b0, 4'hA, 3'd2, 4'h7, 16'd4};
    vecs[13] = '{4'h5, 1'b1, 4'hA, 3'd2, 4'hA, 16'd5};

    rst = 1'b1;
    a   = 4'h0;
    en  = 1'b0;
    sa  = 4'h0;
    sen = 1'b0;

    // Combinational path and reset values while reset is held.
    #4;
    check("comb0_y",    {28'd0, y},    32'hF);
    check("comb0_ones", {29'd0, ones}, 32'd4);
    check("rst_y_q",    {28'd0, y_q},  32'hF);
    check("rst_cnt",    {16'd0, chg_cnt}, 32'd0);
    check("rst_sat_cnt", {30'd0, scnt}, 32'd0);
    a = 4'hA;
    #5;
    check("combA_y",    {28'd0, y},    32'h5);
    check("combA_ones", {29'd0, ones}, 32'd2);
    a = 4'hF;
    #5;
    check("combF_y",    {28'd0, y},    32'h0);
    check("combF_ones", {29'd0, ones}, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Table-driven registered-path, hold and enable-gating vectors.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a   = vecs[i].a;
      en  = vecs[i].en;
      sa  = 4'h0;
      sen = 1'b0;
      e.y_q  = vecs[i].y_q;
      e.cnt  = vecs[i].cnt;
      e.sy_q = 4'hF;
      e.scnt = 2'd0;
      sb.push_back(e);
      #1;
      check($sformatf("vec%0d_y", i),    {28'd0, y},    {28'd0, vecs[i].y});
      check($sformatf("vec%0d_ones", i), {29'd0, ones}, {29'd0, vecs[i].ones});
      @(posedge clk);
      #1;
      pop_compare($sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle after activity.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_y_q", {28'd0, y_q},     32'hF);
    check("arst_cnt", {16'd0, chg_cnt}, 32'd0);
    a = 4'h6;
    #1;
    check("arst_live_y",    {28'd0, y},    32'h9);
    check("arst_live_ones", {29'd0, ones}, 32'd2);

    // Reset wins over enable across a clock edge.
    a  = 4'h7;
    en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_en_y_q", {28'd0, y_q},     32'hF);
    check("rst_en_cnt", {16'd0, chg_cnt}, 32'd0);

    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;

    // Saturation on the 2-bit counter build; main instance holds.
    e = '{4'hF, 16'd0, 4'h0, 2'd1}; step("sat1", 4'h7, 1'b0, 4'hF, 1'b1, e);
    e = '{4'hF, 16'd0, 4'hF, 2'd2}; step("sat2", 4'h7, 1'b0, 4'h0, 1'b1, e);
    e = '{4'hF, 16'd0, 4'h0, 2'd3}; step("sat3", 4'h7, 1'b0, 4'hF, 1'b1, e);
    e = '{4'hF, 16'd0, 4'hF, 2'd3}; step("sat4", 4'h7, 1'b0, 4'h0, 1'b1, e);
    e = '{4'hF, 16'd0, 4'h0, 2'd3}; step("sat5", 4'h7, 1'b0, 4'hF, 1'b1, e);
    e = '{4'hF, 16'd0, 4'hF, 2'd3}; step("sat6", 4'h7, 1'b0, 4'h0, 1'b1, e);

    // First enabled edge after reset with a=0 is not a change.
    e = '{4'hF, 16'd0, 4'hF, 2'd3}; step("first_zero", 4'h0, 1'b1, 4'h0, 1'b0, e);
    e = '{4'h6, 16'd1, 4'hF, 2'd3}; step("first_chg",  4'h9, 1'b1, 4'h0, 1'b0, e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv4.md
Name: inv4

Overview:
- Bitwise inverter. Output `y` is the combinational complement of input `a`, with no clock dependency.
- Adds a registered copy of the inverted value, a population count of the inverted word, and a saturating counter of input changes.
- Used as a small logic-stage / bring-up block between board I/O (switches, LEDs) and downstream logic.

Parameters:
- WIDTH, 4, data width of `a`, `y` and `y_q`; legal range 1..32.
- CNT_W, 16, width of the change counter `chg_cnt`.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  asynchronous active-high reset.
- a  input  WIDTH  data input.
- en  input  1  load enable for `y_q` and for change detection.
- y  output  WIDTH  combinational bitwise NOT of `a`.
- y_q  output  WIDTH  registered bitwise NOT of `a`.
- ones  output  $clog2(WIDTH+1)  number of 1 bits in `y`, combinational.
- chg_cnt  output  CNT_W  saturating count of enabled cycles in which `a` changed.

Behaviour:
- `y = ~a` at all times.
  - Purely combinational: no clock edge needed and no dependency on `rst`.
  - Must be valid within one propagation delay of any change on `a`, including while `rst` is asserted.
- `ones` equals the popcount of `y`, i.e. WIDTH minus the popcount of `a`. Combinational, independent of `rst`.
  - Example: a=4'h0 gives ones=4; a=4'hA gives ones=2; a=4'hF gives ones=0.
- While `rst` is high (asynchronous assert, synchronous-edge release):
  - y_q = all ones (the complement of the reset value of a_prev).
  - Internal a_prev = 0.
  - chg_cnt = 0.
- Rising edge of `clk` with rst=0 and en=1:
  - y_q <= ~a.
  - a_prev <= a.
  - If a != a_prev, chg_cnt <= chg_cnt + 1, saturating at 2^CNT_W-1 (holds at max, no wrap).
- Rising edge of `clk` with rst=0 and en=0: y_q, a_prev and chg_cnt all hold.
- Latency:
  - `y` and `ones`: 0 cycles.
  - `y_q`: 1 cycle after the enabled edge.
  - `chg_cnt`: increments visible 1 cycle after the enabled edge.
- First enabled edge after reset counts a change iff a != 0, because a_prev resets to 0.
- Reset asserted mid-operation:
  - Registers clear immediately, without waiting for a clock edge.
  - `y` and `ones` remain live.
- Simultaneous rst and en: rst wins.
- No X-propagation allowed from the registers after reset.
- No internal state other than a_prev, y_q and chg_cnt.

Test Plan:
- Combinational zero: rst=1, a=0, wait 5 time units with no clock edge -> y=4'hF, ones=4.
- Combinational pattern: a=4'hA, wait 5 time units -> y=4'h5, ones=2. Then a=4'hF -> y=4'h0, ones=0.
- Reset values: assert rst asynchronously mid-cycle after activity -> y_q=4'hF and chg_cnt=0 immediately, before any clock edge.
- Registered path: release rst, a=4'h3, en=1, one clk edge -> y_q=4'hC, chg_cnt=1. Hold a=4'h3 for 3 enabled edges -> chg_cnt stays 1.
- Enable gating: en=0, a toggles 4'h1 -> 4'h2 over 4 edges -> y_q and chg_cnt hold; y tracks ~a combinationally throughout.
- Saturation: CNT_W=2 build, alternate a between 4'h0 and 4'hF with en=1 for 6 edges -> chg_cnt reaches 3 and holds at 3.
